// File: rtl/qspi_xip_ctrl.sv
// qspi_xip_ctrl: execute-in-place front end arbitrating an instruction port and a
// data port onto one QSPI master. Sequential instruction fetches are streamed with
// m_cont so the flash command/address phase is skipped; anything else closes the
// stream with m_stop and restarts with m_start. A watchdog aborts accesses whose
// m_done never arrives.
//
// Handshake: a requester raises *_req with stable fields and holds them until the
// matching *_ready pulse. *_ready is a single-cycle pulse (with *_err on failure).
// A request still high during its own ready cycle is treated as already served,
// so the requester may drop it on the edge that ends the ready cycle.
module qspi_xip_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifetch_req,
    input  logic [23:0] ifetch_addr,
    output logic        ifetch_ready,
    output logic        ifetch_err,
    output logic [31:0] ifetch_rdata,

    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [23:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [5:0]  dmem_len,
    output logic        dmem_ready,
    output logic        dmem_err,
    output logic [31:0] dmem_rdata,

    output logic        m_start,
    output logic        m_stop,
    output logic        m_cont,
    output logic        m_write_enable,
    output logic        m_is_instr,
    output logic [23:0] m_addr,
    output logic [5:0]  m_data_len,
    output logic [31:0] m_data_in,
    input  logic [31:0] m_data_out,
    input  logic        m_done,

    output logic [2:0]  dbg_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT_I = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] WAIT_D = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [5:0] INSTR_LEN = 6'd32;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [23:0] next_addr;
    logic [15:0] wd_cnt;

    logic dmem_go;
    logic ifetch_go;
    logic ifetch_aligned;
    logic stream_hit;

    logic issue_d;
    logic issue_i;
    logic misal;
    logic do_cont;
    logic do_stop;
    logic fin_i;
    logic fin_d;
    logic tmo;

    assign dbg_state = state;

    // Request qualification: ignore a request during its own ready cycle.
    always_comb begin
        dmem_go        = dmem_req && !dmem_ready;
        ifetch_go      = ifetch_req && !ifetch_ready;
        ifetch_aligned = (ifetch_addr[1:0] == 2'b00);
        stream_hit     = (ifetch_addr == next_addr) && (next_addr != 24'd0);
    end

    // Decide this cycle's action. STOP dispatches a still-held request exactly like
    // IDLE does, so the restart m_start lands in the cycle right after m_stop.
    always_comb begin
        issue_d = 1'b0;
        issue_i = 1'b0;
        misal   = 1'b0;
        do_cont = 1'b0;
        do_stop = 1'b0;
        fin_i   = 1'b0;
        fin_d   = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE, STOP: begin
                if (dmem_go) begin
                    issue_d = 1'b1;
                end else if (ifetch_go) begin
                    if (ifetch_aligned) issue_i = 1'b1;
                    else                misal   = 1'b1;
                end
            end
            STREAM: begin
                if (dmem_go) begin
                    do_stop = 1'b1;
                end else if (ifetch_go) begin
                    if (!ifetch_aligned) misal   = 1'b1;
                    else if (stream_hit) do_cont = 1'b1;
                    else                 do_stop = 1'b1;
                end
            end
            WAIT_I, WAIT_D: begin
                if (m_done) begin
                    if (state == WAIT_I) fin_i = 1'b1;
                    else                 fin_d = 1'b1;
                end else if (wd_cnt == TIMEOUT_CYCLES - 16'd1) begin
                    tmo = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next-state selection from the decoded action.
    always_comb begin
        state_nx = state;
        if (issue_d)                state_nx = WAIT_D;
        else if (issue_i || do_cont) state_nx = WAIT_I;
        else if (do_stop)           state_nx = STOP;
        else if (fin_i)             state_nx = STREAM;
        else if (fin_d || tmo)      state_nx = IDLE;
        else if (state == STOP)     state_nx = IDLE;
        else if (state > STOP)      state_nx = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Watchdog: counts cycles spent in a wait state, zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= 16'd0;
        end else if ((state == WAIT_I || state == WAIT_D) && state_nx == state) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= 16'd0;
        end
    end

    // Single-cycle control and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start      <= 1'b0;
            m_stop       <= 1'b0;
            m_cont       <= 1'b0;
            ifetch_ready <= 1'b0;
            ifetch_err   <= 1'b0;
            dmem_ready   <= 1'b0;
            dmem_err     <= 1'b0;
        end else begin
            m_start      <= issue_d || issue_i;
            m_stop       <= do_stop || tmo;
            m_cont       <= do_cont;
            ifetch_ready <= misal || fin_i || (tmo && state == WAIT_I);
            ifetch_err   <= misal || (tmo && state == WAIT_I);
            dmem_ready   <= fin_d || (tmo && state == WAIT_D);
            dmem_err     <= tmo && state == WAIT_D;
        end
    end

    // Master command fields: loaded only when an access starts or continues, so
    // they stay stable for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_write_enable <= 1'b0;
            m_is_instr     <= 1'b0;
            m_addr         <= 24'd0;
            m_data_len     <= 6'd0;
            m_data_in      <= 32'd0;
        end else if (issue_d) begin
            m_write_enable <= dmem_we;
            m_is_instr     <= 1'b0;
            m_addr         <= dmem_addr;
            m_data_len     <= dmem_len;
            m_data_in      <= dmem_wdata;
        end else if (issue_i) begin
            m_write_enable <= 1'b0;
            m_is_instr     <= 1'b1;
            m_addr         <= ifetch_addr;
            m_data_len     <= INSTR_LEN;
            m_data_in      <= 32'd0;
        end else if (do_cont) begin
            m_write_enable <= 1'b0;
            m_is_instr     <= 1'b1;
            m_addr         <= next_addr;
            m_data_len     <= INSTR_LEN;
            m_data_in      <= 32'd0;
        end
    end

    // Stream pointer: the address a continued fetch must present to stay in burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     next_addr <= 24'd0;
        else if (fin_i) next_addr <= m_addr + 24'd4;
    end

    // Read data: updated only on successful completions, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifetch_rdata <= 32'd0;
            dmem_rdata   <= 32'd0;
        end else begin
            if (fin_i) ifetch_rdata <= m_data_out;
            if (fin_d) dmem_rdata   <= m_write_enable ? 32'd0 : m_data_out;
        end
    end

endmodule

// File: tb/tb_qspi_xip_ctrl.sv
// tb_qspi_xip_ctrl: randomized bench for qspi_xip_ctrl. A transaction-level model
// predicts, per request, the master commands (start/cont/stop with fields) and the
// ready/err/rdata responses; a monitor checks the DUT against them every cycle.
module tb_qspi_xip_ctrl;

    localparam int TMO = 100;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ifetch_req;
    logic [23:0] ifetch_addr;
    logic        ifetch_ready;
    logic        ifetch_err;
    logic [31:0] ifetch_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [23:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [5:0]  dmem_len;
    logic        dmem_ready;
    logic        dmem_err;
    logic [31:0] dmem_rdata;
    logic        m_start;
    logic        m_stop;
    logic        m_cont;
    logic        m_write_enable;
    logic        m_is_instr;
    logic [23:0] m_addr;
    logic [5:0]  m_data_len;
    logic [31:0] m_data_in;
    logic [31:0] m_data_out;
    logic        m_done;
    logic [2:0]  dbg_state;

    qspi_xip_ctrl #(.TIMEOUT_CYCLES(16'd100)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .ifetch_ready(ifetch_ready), .ifetch_err(ifetch_err), .ifetch_rdata(ifetch_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_len(dmem_len),
        .dmem_ready(dmem_ready), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
        .m_start(m_start), .m_stop(m_stop), .m_cont(m_cont),
        .m_write_enable(m_write_enable), .m_is_instr(m_is_instr), .m_addr(m_addr),
        .m_data_len(m_data_len), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_done(m_done),
        .dbg_state(dbg_state)
    );

    // Expected master command: kind 0=start 1=cont 2=stop; chain=stop followed by start
    typedef struct packed {
        logic [1:0]  kind;
        logic        chain;
        logic        we;
        logic        instr;
        logic [23:0] addr;
        logic [5:0]  len;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [32:0] exp_i_q[$];
    logic [32:0] exp_d_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_start_cyc = 0;
    logic no_resp = 1'b0;

    // Model state: is a fetch stream open, and what address continues it
    logic        stream = 1'b0;
    logic [23:0] next_a = 24'd0;
    logic [31:0] last_i = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic cmd_t mk(input logic [1:0] k, input logic ch, input logic we,
                                input logic ins, input logic [23:0] a,
                                input logic [5:0] len, input logic [31:0] wd);
        cmd_t c;
        c.kind = k; c.chain = ch; c.we = we; c.instr = ins;
        c.addr = a; c.len = len; c.wdata = wd;
        return c;
    endfunction

    // Flash contents seen by the bench master
    function automatic logic [31:0] mem_word(input logic [23:0] a);
        if (a == 24'h000100) return 32'hDEADBEEF;
        return {a[7:0], a} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [23:0] rand_aligned();
        logic [31:0] r;
        r = $urandom;
        return {r[23:2], 2'b00};
    endfunction

    // Master model: answers each start/cont after 1..5 cycles with one m_done pulse
    task automatic responder();
        int lat;
        logic [23:0] a;
        logic we;
        forever begin
            @(negedge clk);
            if (rst_n && (m_start || m_cont) && !no_resp) begin
                a = m_addr;
                we = m_write_enable;
                lat = $urandom_range(1, 5);
                repeat (lat) @(posedge clk);
                #1;
                if (rst_n) begin
                    m_done = 1'b1;
                    m_data_out = we ? 32'hFFFF_FFFF : mem_word(a);
                    @(posedge clk); #1;
                    m_done = 1'b0;
                end
            end
        end
    endtask

    // Scoreboard monitor: checks master commands, field stability and responses
    task automatic monitor();
        cmd_t c;
        logic [63:0] snap;
        logic [63:0] fields;
        logic [2:0] pulses;
        logic [2:0] prev_pulses;
        logic [1:0] kind;
        logic busy;
        logic want_start;
        logic [32:0] e;
        busy = 1'b0; want_start = 1'b0; prev_pulses = 3'b000; snap = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy = 1'b0; want_start = 1'b0; prev_pulses = 3'b000;
                continue;
            end
            pulses = {m_start, m_cont, m_stop};
            fields = {m_write_enable, m_is_instr, m_addr, m_data_len, m_data_in};
            if (want_start) begin
                chk("start_after_stop", m_start, 1);
                want_start = 1'b0;
            end
            if (pulses != 3'b000) begin
                chk("ctrl_onehot", $onehot(pulses), 1);
                chk("ctrl_single_cycle", prev_pulses & pulses, 0);
                kind = m_start ? 2'd0 : (m_cont ? 2'd1 : 2'd2);
                chk("cmd_expected", cmd_q.size() != 0, 1);
                if (cmd_q.size() != 0) begin
                    c = cmd_q.pop_front();
                    chk("cmd_kind", kind, c.kind);
                    if (kind != 2'd2) begin
                        chk("cmd_fields", fields, {c.we, c.instr, c.addr, c.len, c.wdata});
                        snap = fields;
                        busy = 1'b1;
                        last_start_cyc = cyc;
                    end else begin
                        busy = 1'b0;
                        if (c.chain) begin
                            want_start = 1'b1;
                        end else begin
                            chk("tmo_cycles", cyc - last_start_cyc, TMO);
                            chk("tmo_ready_err", {ifetch_ready, ifetch_err}, 2'b11);
                        end
                    end
                end
            end else if (busy) begin
                chk("fields_stable", fields, snap);
            end
            if (busy && m_done) busy = 1'b0;
            if (ifetch_ready) begin
                chk("ifetch_ready_expected", exp_i_q.size() != 0, 1);
                if (exp_i_q.size() != 0) begin
                    e = exp_i_q.pop_front();
                    chk("ifetch_resp", {ifetch_err, ifetch_rdata}, e);
                end
            end
            if (dmem_ready) begin
                chk("dmem_ready_expected", exp_d_q.size() != 0, 1);
                if (exp_d_q.size() != 0) begin
                    e = exp_d_q.pop_front();
                    chk("dmem_resp", {dmem_err, dmem_rdata}, e);
                end
            end
            if (ifetch_err && !ifetch_ready) chk("ifetch_err_alone", ifetch_err, 0);
            if (dmem_err && !dmem_ready) chk("dmem_err_alone", dmem_err, 0);
            prev_pulses = pulses;
        end
    endtask

    // Model prediction for one instruction fetch
    task automatic expect_ifetch(input logic [23:0] a);
        if (a[1:0] != 2'b00) begin
            exp_i_q.push_back({1'b1, last_i});
        end else begin
            if (stream && a == next_a && next_a != 24'd0) begin
                cmd_q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b1, a, 6'd32, 32'd0));
            end else begin
                if (stream) cmd_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 24'd0, 6'd0, 32'd0));
                cmd_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, a, 6'd32, 32'd0));
            end
            last_i = mem_word(a);
            exp_i_q.push_back({1'b0, last_i});
            stream = 1'b1;
            next_a = a + 24'd4;
        end
    endtask

    // Model prediction for one data access
    task automatic expect_dmem(input logic we, input logic [23:0] a,
                               input logic [31:0] wd, input logic [5:0] len);
        if (stream) cmd_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 24'd0, 6'd0, 32'd0));
        cmd_q.push_back(mk(2'd0, 1'b0, we, 1'b0, a, len, wd));
        exp_d_q.push_back({1'b0, we ? 32'd0 : mem_word(a)});
        stream = 1'b0;
    endtask

    task automatic do_ifetch(input logic [23:0] a);
        int n;
        logic got;
        expect_ifetch(a);
        ifetch_req = 1'b1; ifetch_addr = a;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            got = ifetch_ready;
        end
        ifetch_req = 1'b0;
        chk("ifetch_completed", got, 1);
        if (a[1:0] != 2'b00) chk("misaligned_latency", n, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_dmem(input logic we, input logic [23:0] a,
                           input logic [31:0] wd, input logic [5:0] len);
        int n;
        logic got;
        expect_dmem(we, a, wd, len);
        dmem_req = 1'b1; dmem_we = we; dmem_addr = a; dmem_wdata = wd; dmem_len = len;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            got = dmem_ready;
        end
        dmem_req = 1'b0;
        chk("dmem_completed", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_both(input logic [23:0] ia, input logic we, input logic [23:0] da,
                           input logic [31:0] wd, input logic [5:0] len);
        int n;
        logic gi, gd, dfirst;
        expect_dmem(we, da, wd, len);
        expect_ifetch(ia);
        ifetch_req = 1'b1; ifetch_addr = ia;
        dmem_req = 1'b1; dmem_we = we; dmem_addr = da; dmem_wdata = wd; dmem_len = len;
        n = 0; gi = 1'b0; gd = 1'b0; dfirst = 1'b0;
        while (!(gi && gd) && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (!gd && dmem_ready) begin
                gd = 1'b1; dmem_req = 1'b0;
                if (!gi) dfirst = 1'b1;
            end
            if (!gi && ifetch_ready) begin
                gi = 1'b1; ifetch_req = 1'b0;
            end
        end
        ifetch_req = 1'b0; dmem_req = 1'b0;
        chk("both_completed", {gi, gd}, 2'b11);
        chk("dmem_served_first", dfirst, 1);
        @(posedge clk); #1;
    endtask

    // Fetch that the master never answers: watchdog abort
    task automatic do_timeout(input logic [23:0] a);
        int n;
        logic got;
        no_resp = 1'b1;
        if (stream) cmd_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 24'd0, 6'd0, 32'd0));
        cmd_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, a, 6'd32, 32'd0));
        cmd_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 24'd0, 6'd0, 32'd0));
        exp_i_q.push_back({1'b1, last_i});
        stream = 1'b0;
        ifetch_req = 1'b1; ifetch_addr = a;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            got = ifetch_ready;
        end
        ifetch_req = 1'b0;
        chk("tmo_completed", got, 1);
        @(posedge clk); #1;
        no_resp = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {ifetch_ready, ifetch_err, |ifetch_rdata, dmem_ready, dmem_err,
                   |dmem_rdata, m_start, m_stop, m_cont, m_write_enable, m_is_instr,
                   |m_addr, |m_data_len, |m_data_in, |dbg_state}, 0);
    endtask

    // Reset in the middle of an outstanding fetch
    task automatic do_reset_mid();
        no_resp = 1'b1;
        if (stream) cmd_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 24'd0, 6'd0, 32'd0));
        cmd_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, 24'h000500, 6'd32, 32'd0));
        ifetch_req = 1'b1; ifetch_addr = 24'h000500;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0; ifetch_req = 1'b0;
        #1;
        check_outputs_zero("reset_mid_outputs_zero");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream = 1'b0; next_a = 24'd0; last_i = 32'd0; no_resp = 1'b0;
        chk("reset_mid_queues_empty", cmd_q.size() + exp_i_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        do_ifetch(24'h000104);
    endtask

    initial begin
        logic [23:0] a;
        logic [1:0] lo;
        int r;
        rst_n = 1'b0;
        ifetch_req = 1'b0; ifetch_addr = 24'd0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = 24'd0; dmem_wdata = 32'd0; dmem_len = 6'd0;
        m_done = 1'b0; m_data_out = 32'd0;
        fork
            responder();
            monitor();
            begin
                #1000000;
                $display("FAIL global_timeout: run exceeded its time limit");
                $fatal(1, "run aborted");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs_zero");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios with hand-computed anchors
        do_ifetch(24'h000100);
        chk("lit_ifetch_rdata_100", ifetch_rdata, 32'hDEADBEEF);
        do_ifetch(24'h000104);
        do_ifetch(24'h000200);
        do_dmem(1'b1, 24'h000040, 32'h12345678, 6'd32);
        chk("lit_dmem_write_rdata", dmem_rdata, 32'd0);
        do_both(24'h000300, 1'b0, 24'h000080, 32'd0, 6'd4);
        do_ifetch(24'h000102);
        chk("lit_misaligned_keeps_rdata", ifetch_rdata, mem_word(24'h000300));
        do_ifetch(24'hFFFFFC);
        do_ifetch(24'h000000);
        do_dmem(1'b0, 24'h001000, 32'd0, 6'd8);
        do_timeout(24'h000600);
        do_ifetch(24'h000700);
        do_reset_mid();

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                do_ifetch(stream ? next_a : rand_aligned());
            end else if (r < 60) begin
                do_ifetch(rand_aligned());
            end else if (r < 70) begin
                a = rand_aligned();
                lo = 2'($urandom_range(1, 3));
                a[1:0] = lo;
                do_ifetch(a);
            end else if (r < 90) begin
                a = 24'($urandom);
                do_dmem(1'($urandom_range(0, 1)), a, $urandom, 6'($urandom_range(1, 63)));
            end else begin
                a = 24'($urandom);
                do_both(rand_aligned(), 1'($urandom_range(0, 1)), a, $urandom,
                        6'($urandom_range(1, 63)));
            end
        end

        repeat (10) @(posedge clk);
        #1;
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("ifetch_q_drained", exp_i_q.size(), 0);
        chk("dmem_q_drained", exp_d_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
